// File: rtl/divisibility_flags_serial_pkg.sv
// divisibility_pkg: shared FSM state type and remainder-width helper
//   state_t  - IDLE / SHIFT / DONE for the serial divisibility FSM
//   rem_w()  - bits needed to hold a remainder modulo div (div >= 2)
package divisibility_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   function automatic int rem_w(input int div);
      return $clog2(div);
   endfunction
endpackage

// File: rtl/divisibility_flags_serial_if.sv
// divisibility_flags_serial_if: operand/result handshake bundle
//   in_valid/in_ready/in_data   operand channel (master -> slave)
//   out_valid/out_ready         result channel (slave -> master)
//   flag_a/flag_b               result flags, valid with out_valid
interface divisibility_flags_serial_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             flag_a;
   logic             flag_b;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, flag_a, flag_b);
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, flag_a, flag_b);
endinterface

// File: rtl/divisibility_flags_serial_mod_step.sv
// mod_step: one MSB-first running-remainder step, rem_next = (2*rem + bit_in) mod DIV
//   rem       in   current remainder, always < DIV
//   bit_in    in   next operand bit
//   rem_next  out  updated remainder, always < DIV
module mod_step
   import divisibility_pkg::*;
#(
   parameter int DIV = 3
) (
   input  logic [rem_w(DIV)-1:0] rem,
   input  logic                  bit_in,
   output logic [rem_w(DIV)-1:0] rem_next
);
   localparam int RW = rem_w(DIV);
   logic [RW:0] t;
   // 2*rem+1 <= 2*DIV-1, so a single conditional subtract always lands below DIV
   assign t = {rem, bit_in};
   assign rem_next = (t >= (RW+1)'(DIV)) ? RW'(t - (RW+1)'(DIV)) : t[RW-1:0];
endmodule

// File: rtl/divisibility_flags_serial.sv
// divisibility_flags_serial: bit-serial "nonzero multiple of DIV_A / DIV_B" flag generator
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport: operand handshake in, result handshake + flags out
//   busy   out  high whenever the FSM is not IDLE
module divisibility_flags_serial
   import divisibility_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DIV_A     = 3,
   parameter int DIV_B     = 2,
   parameter bit ZERO_FLAG = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   divisibility_flags_serial_if.slave     bus,
   output logic                           busy
);
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int RWA = rem_w(DIV_A);
   localparam int RWB = rem_w(DIV_B);

   if (WIDTH < 1 || DIV_A < 2 || DIV_B < 2) begin : g_bad_param
      $error("divisibility_flags_serial: need WIDTH>=1, DIV_A>=2, DIV_B>=2");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RWA-1:0]   rem_a_q, rem_a_d, nxt_a;
   logic [RWB-1:0]   rem_b_q, rem_b_d, nxt_b;
   logic             nz_q, nz_d;
   logic             flag_a_q, flag_a_d;
   logic             flag_b_q, flag_b_d;
   logic             last;

   mod_step #(.DIV(DIV_A)) u_step_a (.rem(rem_a_q), .bit_in(sr_q[WIDTH-1]), .rem_next(nxt_a));
   mod_step #(.DIV(DIV_B)) u_step_b (.rem(rem_b_q), .bit_in(sr_q[WIDTH-1]), .rem_next(nxt_b));

   assign last = cnt_q == CW'(WIDTH - 1);

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      rem_a_d  = rem_a_q;
      rem_b_d  = rem_b_q;
      nz_d     = nz_q;
      flag_a_d = flag_a_q;
      flag_b_d = flag_b_q;
      unique case (state_q)
         IDLE: if (bus.in_valid) begin
            state_d = SHIFT;
            sr_d    = bus.in_data;
            cnt_d   = '0;
            rem_a_d = '0;
            rem_b_d = '0;
            nz_d    = |bus.in_data;
         end
         SHIFT: begin
            sr_d    = sr_q << 1;
            rem_a_d = nxt_a;
            rem_b_d = nxt_b;
            // counter saturates at WIDTH-1; it is reloaded on the next accept
            cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            if (last) begin
               state_d  = DONE;
               flag_a_d = (nxt_a == '0) & (nz_q | ZERO_FLAG);
               flag_b_d = (nxt_b == '0) & (nz_q | ZERO_FLAG);
            end
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         rem_a_q  <= '0;
         rem_b_q  <= '0;
         nz_q     <= 1'b0;
         flag_a_q <= 1'b0;
         flag_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         rem_a_q  <= rem_a_d;
         rem_b_q  <= rem_b_d;
         nz_q     <= nz_d;
         flag_a_q <= flag_a_d;
         flag_b_q <= flag_b_d;
      end
   end

   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.flag_a    = flag_a_q;
   assign bus.flag_b    = flag_b_q;
   assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_divisibility_flags_serial.sv
// tb_divisibility_flags_serial: directed self-checking bench for three configurations
module tb_divisibility_flags_serial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total = 0;

   logic       iv[3];
   logic [7:0] din[3];
   logic       ordy[3];
   logic       ov[3], ir[3], fa[3], fb[3], bz[3];

   always #5 clk = ~clk;

   divisibility_flags_serial_if #(.WIDTH(4)) if0 ();
   divisibility_flags_serial_if #(.WIDTH(4)) if1 ();
   divisibility_flags_serial_if #(.WIDTH(8)) if2 ();

   divisibility_flags_serial #(.WIDTH(4), .DIV_A(3), .DIV_B(2), .ZERO_FLAG(1'b0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(bz[0]));
   divisibility_flags_serial #(.WIDTH(4), .DIV_A(3), .DIV_B(2), .ZERO_FLAG(1'b1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(bz[1]));
   divisibility_flags_serial #(.WIDTH(8), .DIV_A(7), .DIV_B(2), .ZERO_FLAG(1'b0))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .busy(bz[2]));

   assign if0.in_valid = iv[0];
   assign if1.in_valid = iv[1];
   assign if2.in_valid = iv[2];
   assign if0.in_data = din[0][3:0];
   assign if1.in_data = din[1][3:0];
   assign if2.in_data = din[2];
   assign if0.out_ready = ordy[0];
   assign if1.out_ready = ordy[1];
   assign if2.out_ready = ordy[2];
   assign ov[0] = if0.out_valid;
   assign ov[1] = if1.out_valid;
   assign ov[2] = if2.out_valid;
   assign ir[0] = if0.in_ready;
   assign ir[1] = if1.in_ready;
   assign ir[2] = if2.in_ready;
   assign fa[0] = if0.flag_a;
   assign fa[1] = if1.flag_a;
   assign fa[2] = if2.flag_a;
   assign fb[0] = if0.flag_b;
   assign fb[1] = if1.flag_b;
   assign fb[2] = if2.flag_b;

   // one operand through DUT k; returns flags and edges from accept to out_valid
   task automatic xact(input int k, input logic [7:0] d, output logic fa_o, output logic fb_o,
                       output int lat);
      iv[k] = 1'b1;
      din[k] = d;
      @(posedge clk); #1;
      iv[k] = 1'b0;
      lat = 1;
      while (!ov[k] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      fa_o = fa[k];
      fb_o = fb[k];
      ordy[k] = 1'b1;
      @(posedge clk); #1;
      ordy[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++; if ({ir[0], ov[0], fa[0], fb[0], bz[0]} !== 5'b10000) $display("FAIL reset0 got %b want 10000", {ir[0], ov[0], fa[0], fb[0], bz[0]}); else pass_cnt++;
      total++; if ({ir[2], ov[2], fa[2], fb[2], bz[2]} !== 5'b10000) $display("FAIL reset2 got %b want 10000", {ir[2], ov[2], fa[2], fb[2], bz[2]}); else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if ({ir[0], ov[0], bz[0]} !== 3'b100) $display("FAIL idle_after_reset got %b want 100", {ir[0], ov[0], bz[0]}); else pass_cnt++;
   endtask

   task automatic test_basic();
      logic a, b;
      int lat;
      logic [3:0] vec[4] = '{4'd9, 4'd6, 4'd14, 4'd15};
      logic [1:0] exp[4] = '{2'b10, 2'b11, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
         xact(0, {4'd0, vec[i]}, a, b, lat);
         total++; if ({a, b} !== exp[i]) $display("FAIL basic_%0d flags got %b want %b", vec[i], {a, b}, exp[i]); else pass_cnt++;
         total++; if (lat !== 5) $display("FAIL basic_%0d latency got %0d want 5", vec[i], lat); else pass_cnt++;
      end
   endtask

   task automatic test_zero();
      logic a, b;
      int lat;
      xact(0, 8'd0, a, b, lat);
      total++; if ({a, b} !== 2'b00) $display("FAIL zero_nzflag got %b want 00", {a, b}); else pass_cnt++;
      xact(1, 8'd0, a, b, lat);
      total++; if ({a, b} !== 2'b11) $display("FAIL zero_zflag got %b want 11", {a, b}); else pass_cnt++;
      xact(1, 8'd9, a, b, lat);
      total++; if ({a, b} !== 2'b10) $display("FAIL zflag_9 got %b want 10", {a, b}); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int n;
      iv[0] = 1'b1;
      din[0] = 8'd12;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      n = 0;
      while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
      total++; if (ov[0] !== 1'b1) $display("FAIL bp_wait out_valid got %b want 1", ov[0]); else pass_cnt++;
      din[0] = 8'd1;
      for (int i = 0; i < 5; i++) begin
         iv[0] = i[0];
         @(posedge clk); #1;
         total++; if ({ov[0], fa[0], fb[0], ir[0], bz[0]} !== 5'b11101) $display("FAIL bp_hold_%0d got %b want 11101", i, {ov[0], fa[0], fb[0], ir[0], bz[0]}); else pass_cnt++;
      end
      iv[0] = 1'b1;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      total++; if ({ir[0], ov[0], bz[0], fa[0], fb[0]} !== 5'b10011) $display("FAIL bp_release got %b want 10011", {ir[0], ov[0], bz[0], fa[0], fb[0]}); else pass_cnt++;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      total++; if ({ir[0], bz[0]} !== 2'b01) $display("FAIL bp_accept_next got %b want 01", {ir[0], bz[0]}); else pass_cnt++;
      n = 1;
      while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
      total++; if ({n, fa[0], fb[0]} !== {32'd5, 2'b00}) $display("FAIL bp_next lat/flags got %0d/%b want 5/00", n, {fa[0], fb[0]}); else pass_cnt++;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic a, b;
      int lat;
      xact(0, 8'd6, a, b, lat);
      iv[0] = 1'b1;
      din[0] = 8'd5;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++; if ({ir[0], ov[0], fa[0], fb[0], bz[0]} !== 5'b10000) $display("FAIL midrst got %b want 10000", {ir[0], ov[0], fa[0], fb[0], bz[0]}); else pass_cnt++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         total++; if ({ov[0], bz[0]} !== 2'b00) $display("FAIL midrst_quiet_%0d got %b want 00", i, {ov[0], bz[0]}); else pass_cnt++;
      end
      xact(0, 8'd3, a, b, lat);
      total++; if ({a, b, lat} !== {2'b10, 32'd5}) $display("FAIL midrst_next got %b/%0d want 10/5", {a, b}, lat); else pass_cnt++;
   endtask

   task automatic test_wide();
      logic a, b;
      int lat;
      logic ea, eb;
      xact(2, 8'd252, a, b, lat);
      total++; if ({a, b, lat} !== {2'b11, 32'd9}) $display("FAIL wide_252 got %b/%0d want 11/9", {a, b}, lat); else pass_cnt++;
      xact(2, 8'd250, a, b, lat);
      total++; if ({a, b} !== 2'b01) $display("FAIL wide_250 got %b want 01", {a, b}); else pass_cnt++;
      for (int v = 0; v < 256; v++) begin
         xact(2, 8'(v), a, b, lat);
         ea = (v % 7 == 0) && (v != 0);
         eb = (v % 2 == 0) && (v != 0);
         total++; if ({a, b, lat} !== {ea, eb, 32'd9}) $display("FAIL wide_sweep_%0d got %b/%0d want %b/9", v, {a, b}, lat, {ea, eb}); else pass_cnt++;
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0;
         din[k] = 8'd0;
         ordy[k] = 1'b0;
      end
      test_reset();
      test_basic();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_wide();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
